// File: rtl/cmd_auth_rx.sv
// cmd_auth_rx: 8N1 UART receiver feeding a power-authorization FSM.
// 'G' authorizes power; 'S' de-authorizes once the rider has stepped off.
// Optional command watchdog compiled in with `define CMD_TIMEOUT_EN.
module cmd_auth_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter logic [7:0]  GO_CMD   = 8'h47,
  parameter logic [7:0]  STOP_CMD = 8'h53
`ifdef CMD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 2**24
`endif
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       framing_err,
  output logic       pwr_up
);

  localparam logic [11:0] LP_DIV  = 12'(BAUD_DIV);
  localparam logic [11:0] LP_HALF = 12'(BAUD_DIV / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [1:0] {AU_OFF, AU_PWR1, AU_PWR2} au_st_e;

  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  logic        w_fall;
  rx_st_e      r_rx_st, w_rx_nxt;
  logic [11:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_rx_data, w_data_nxt;
  logic        r_rx_rdy, w_rdy_nxt;
  logic        r_ferr, w_ferr_nxt;
  au_st_e      r_au_st, w_au_nxt;
  logic        r_pwr_up;

  // Two-flop RX synchronizer plus history flop; presets high so a line
  // that is already low at reset release is not mistaken for an idle line.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_s3 & ~r_rx_s2;

  // RX state, bit timing, shift register and output pulse registers.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_rx_st   <= RX_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_rx_rdy  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_st   <= w_rx_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_rx_data <= w_data_nxt;
      r_rx_rdy  <= w_rdy_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  // RX next-state: half-bit wait to centre, then one sample per bit period.
  always_comb begin
    w_rx_nxt    = r_rx_st;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_rx_data;
    w_rdy_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_rx_st)
      RX_IDLE: begin
        if (w_fall) begin
          w_baud_nxt = LP_HALF;
          w_rx_nxt   = RX_START;
        end
      end
      RX_START: begin
        if (r_baud == '0) begin
          if (r_rx_s2) begin
            w_rx_nxt = RX_IDLE;
          end else begin
            w_baud_nxt = LP_DIV;
            w_bit_nxt  = '0;
            w_rx_nxt   = RX_DATA;
          end
        end else begin
          w_baud_nxt = r_baud - 12'd1;
        end
      end
      RX_DATA: begin
        if (r_baud == '0) begin
          w_shift_nxt = {r_rx_s2, r_shift[7:1]};
          w_baud_nxt  = LP_DIV;
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_rx_nxt = RX_STOP;
        end else begin
          w_baud_nxt = r_baud - 12'd1;
        end
      end
      RX_STOP: begin
        if (r_baud == '0) begin
          if (r_rx_s2) begin
            w_data_nxt = r_shift;
            w_rdy_nxt  = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
          w_rx_nxt = RX_IDLE;
        end else begin
          w_baud_nxt = r_baud - 12'd1;
        end
      end
      default: w_rx_nxt = RX_IDLE;
    endcase
  end

`ifdef CMD_TIMEOUT_EN
  localparam logic [24:0] LP_TO = 25'(TIMEOUT_CYC);
  logic [24:0] r_wdog;
  logic        w_timeout;

  // Watchdog: idle while off, restarted by every good byte, saturates at limit.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n)                               r_wdog <= '0;
    else if (r_au_st == AU_OFF || r_rx_rdy)   r_wdog <= '0;
    else if (r_wdog != LP_TO)                 r_wdog <= r_wdog + 25'd1;
  end

  assign w_timeout = (r_wdog == LP_TO) && rider_off;
`endif

  // Auth state register; pwr_up is registered from the next state.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_au_st  <= AU_OFF;
      r_pwr_up <= 1'b0;
    end else begin
      r_au_st  <= w_au_nxt;
      r_pwr_up <= (w_au_nxt != AU_OFF);
    end
  end

  // Auth next-state: only good bytes and the rider_off level move it.
  always_comb begin
    w_au_nxt = r_au_st;
    case (r_au_st)
      AU_OFF: begin
        if (r_rx_rdy && r_rx_data == GO_CMD) w_au_nxt = AU_PWR1;
      end
      AU_PWR1: begin
        if (r_rx_rdy && r_rx_data == STOP_CMD)
          w_au_nxt = rider_off ? AU_OFF : AU_PWR2;
`ifdef CMD_TIMEOUT_EN
        else if (!(r_rx_rdy && r_rx_data == GO_CMD) && w_timeout)
          w_au_nxt = AU_OFF;
`endif
      end
      AU_PWR2: begin
        if (r_rx_rdy && r_rx_data == GO_CMD) w_au_nxt = AU_PWR1;
        else if (rider_off)                  w_au_nxt = AU_OFF;
      end
      default: w_au_nxt = AU_OFF;
    endcase
  end

  assign rx_data     = r_rx_data;
  assign rx_rdy      = r_rx_rdy;
  assign framing_err = r_ferr;
  assign pwr_up      = r_pwr_up;

endmodule

// File: tb/tb_cmd_auth_rx.sv
// Bench for cmd_auth_rx: directed scenarios plus randomized command bytes
// checked against a rule-level model of the power authorization.
module tb_cmd_auth_rx;
  localparam int unsigned B = 64;
  localparam logic [7:0] G = 8'h47;
  localparam logic [7:0] S = 8'h53;

  logic       clk = 1'b0;
  logic       RST_n;
  logic       RX;
  logic       rider_off;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       framing_err;
  logic       pwr_up;

  int n_chk = 0;
  int n_err = 0;
  int n_rdy = 0;
  int n_ferr = 0;
  int last_lat = 0;

  // Reference model: power granted flag and a stop that waits for rider_off.
  logic m_pwr = 1'b0;
  logic m_pend = 1'b0;

  always #5 clk = ~clk;

  cmd_auth_rx #(
    .BAUD_DIV(B)
`ifdef CMD_TIMEOUT_EN
    , .TIMEOUT_CYC(5000)
`endif
  ) dut (
    .clk(clk), .RST_n(RST_n), .RX(RX), .rider_off(rider_off),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .framing_err(framing_err), .pwr_up(pwr_up)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_rdy) n_rdy++;
    if (framing_err) n_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == G) begin
      m_pwr = 1'b1;
      m_pend = 1'b0;
    end else if (b == S && m_pwr) begin
      if (rider_off) begin
        m_pwr = 1'b0;
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic model_rider();
    if (m_pend && rider_off) begin
      m_pwr = 1'b0;
      m_pend = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_stop);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = good_stop;
    repeat (B) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic wait_rdy(input logic [7:0] exp_d, input logic pre, input logic post);
    logic seen = 1'b0;
    int lat = 0;
    for (int i = 0; i < 12 * B; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (rx_rdy) begin
        seen = 1'b1;
        break;
      end
    end
    check("rdy_seen", seen, 1);
    if (seen) begin
      check("rx_data", rx_data, exp_d);
      check("pwr_at_rdy", pwr_up, pre);
      @(negedge clk);
      check("pwr_after_rdy", pwr_up, post);
      check("rdy_one_cycle", rx_rdy, 0);
    end
    last_lat = lat;
  endtask

  task automatic xfer(input logic [7:0] b);
    logic pre;
    logic post;
    pre = m_pwr;
    model_byte(b);
    post = m_pwr;
    fork
      send_frame(b, 1'b1);
      wait_rdy(b, pre, post);
    join
  endtask

  initial begin
    int r0;
    int f0;
    logic pre;
    logic post;
    logic [7:0] b;
    RST_n = 1'b0;
    RX = 1'b1;
    rider_off = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_rdy", rx_rdy, 0);
    check("rst_ferr", framing_err, 0);
    check("rst_pwr", pwr_up, 0);
    RST_n = 1'b1;
    repeat (5) @(negedge clk);

    // GO authorizes; latency about ten bit times from the start edge.
    r0 = n_rdy;
    xfer(G);
    check("go_latency_ok", (last_lat >= 9 * B && last_lat <= 11 * B), 1);
    repeat (B) @(negedge clk);
    check("go_one_rdy", n_rdy - r0, 1);
    check("go_no_ferr", n_ferr, 0);

    // STOP with rider on holds power until rider_off rises.
    xfer(S);
    repeat (B) @(negedge clk);
    check("stop_pending_pwr", pwr_up, 1);
    rider_off = 1'b1;
    model_rider();
    @(negedge clk);
    check("rider_off_drop", pwr_up, m_pwr);

    // STOP with rider off drops at once; other bytes are ignored.
    xfer(G);
    repeat (B) @(negedge clk);
    xfer(S);
    repeat (B) @(negedge clk);
    xfer(8'h41);
    repeat (B) @(negedge clk);
    check("other_byte_pwr", pwr_up, 0);

    // Bad stop bit: framing error only, data and power unchanged.
    r0 = n_rdy;
    f0 = n_ferr;
    send_frame(G, 1'b0);
    repeat (2 * B) @(negedge clk);
    check("ferr_pulse", n_ferr - f0, 1);
    check("ferr_no_rdy", n_rdy - r0, 0);
    check("ferr_data_hold", rx_data, 8'h41);
    check("ferr_pwr_hold", pwr_up, 0);

    // Short low glitch is rejected without any pulse.
    r0 = n_rdy;
    f0 = n_ferr;
    RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    RX = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("glitch_no_rdy", n_rdy - r0, 0);
    check("glitch_no_ferr", n_ferr - f0, 0);

    // Back-to-back STOP then GO while waiting for rider.
    rider_off = 1'b0;
    @(negedge clk);
    xfer(G);
    repeat (B) @(negedge clk);
    xfer(S);
    repeat (B) @(negedge clk);
    r0 = n_rdy;
    fork
      begin
        send_frame(S, 1'b1);
        send_frame(G, 1'b1);
      end
      begin
        pre = m_pwr; model_byte(S); post = m_pwr;
        wait_rdy(S, pre, post);
        pre = m_pwr; model_byte(G); post = m_pwr;
        wait_rdy(G, pre, post);
      end
    join
    check("b2b_two_rdy", n_rdy - r0, 2);
    check("b2b_pwr", pwr_up, 1);

    // Reset mid-frame: power drops asynchronously, partial byte discarded.
    r0 = n_rdy;
    fork
      send_frame(G, 1'b1);
      begin
        repeat (5 * B) @(negedge clk);
        RST_n = 1'b0;
        #1;
        check("async_rst_pwr", pwr_up, 0);
      end
    join
    repeat (3) @(negedge clk);
    RST_n = 1'b1;
    m_pwr = 1'b0;
    m_pend = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_no_rdy", n_rdy - r0, 0);
    check("rst_mid_data", rx_data, 0);
    xfer(G);
    repeat (B) @(negedge clk);

    // Randomized command stream against the model.
    for (int k = 0; k < 40; k++) begin
      rider_off = 1'($urandom_range(0, 1));
      model_rider();
      repeat (2) @(negedge clk);
      check("rand_pwr_idle", pwr_up, m_pwr);
      case ($urandom_range(0, 3))
        0: b = G;
        1: b = S;
        default: b = 8'($urandom);
      endcase
      xfer(b);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    check("rand_no_ferr", n_ferr - f0, 0);

`ifdef CMD_TIMEOUT_EN
    // Watchdog never drops power under a rider; it fires once rider_off rises.
    rider_off = 1'b0;
    @(negedge clk);
    xfer(G);
    repeat (5100) @(negedge clk);
    check("to_hold_rider", pwr_up, 1);
    rider_off = 1'b1;
    @(negedge clk);
    check("to_drop", pwr_up, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
